// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes and default timings.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // 120 us inhibit and 15 ms inter-edge timeout at 50 MHz
  localparam int unsigned DEFAULT_INHIBIT_CYCLES = 6000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for one PS/2 line.
// Define PS2_HOST_TX_FILTER_EN to insert an 8-sample stability filter before edge detection.
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Lines idle high, so the chain resets to 1 to avoid a phantom edge after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
    end
  end

`ifdef PS2_HOST_TX_FILTER_EN
  logic [7:0] hist_q;
  logic       filt_q;

  // Level only moves once all eight recent samples agree
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hist_q <= 8'hFF;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[6:0], sync_q};
      if (&hist_q) begin
        filt_q <= 1'b1;
      end else if (~|hist_q) begin
        filt_q <= 1'b0;
      end
    end
  end

  assign level_o = filt_q;
`else
  assign level_o = sync_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_o;
    end
  end

  assign fall_o = prev_q & ~level_o;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then shifts one
// command byte out on device clock falls and checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  ps2_state_e     state_q, state_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [ToW-1:0]  to_q, to_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            bit_q, bit_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic clk_level, clk_fall;
  logic dat_level, unused_dat_fall;
  logic to_hit;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .resetn  (resetn),
    .pad_i   (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk     (clk),
    .resetn  (resetn),
    .pad_i   (ps2_dat_in),
    .level_o (dat_level),
    .fall_o  (unused_dat_fall)
  );

  assign to_hit = (to_q == ToLast);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      inh_q   <= '0;
      to_q    <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    to_d    = to_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_d = 1'b0;
        if (cmd_valid) begin
          data_d  = cmd_data;
          par_d   = odd_parity(cmd_data);
          idx_d   = '0;
          inh_d   = '0;
          state_d = StInhibit;
        end
      end

      StInhibit: begin
        if (inh_q == InhLast) begin
          state_d = StReq;
        end else begin
          inh_d = inh_q + InhW'(1);
        end
      end

      StReq: begin
        // Start bit keeps data low until the device's first falling edge
        bit_d   = 1'b1;
        to_d    = '0;
        state_d = StShift;
      end

      StShift: begin
        if (clk_fall) begin
          to_d  = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q < 4'd8) begin
            bit_d = ~data_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            bit_d = ~par_q;
          end else begin
            bit_d   = 1'b0;
            state_d = StAck;
          end
        end else if (to_hit) begin
          bit_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end

      StAck: begin
        if (clk_fall) begin
          to_d = '0;
          if (!dat_level) begin
            state_d = StWaitIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end

      StWaitIdle: begin
        if (clk_level && dat_level) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (clk_fall) begin
          to_d = '0;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end

      default: begin
        bit_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign ps2_clk_oe = (state_q == StInhibit) || (state_q == StReq);
  assign ps2_dat_oe = (state_q == StReq) || ((state_q == StShift) && bit_q);
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (for example 0xED to set LEDs, or 0xFF to reset) over the same PS2_CLK/PS2_DAT pair that keyboard_tracker receives on. It is the sending end of the PS/2 link and sits beside the receiver in the top-level game module. It drives the lines open-drain through active-high pull-low enables; the top level ties each pad to 0 when its enable is high, otherwise to Z.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles the host holds the clock low before the request (120 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles allowed between device clock falling edges before abort (15 ms).

Ports:
clk  in  1  system clock, 50 MHz.
resetn  in  1  synchronous active-low reset.
cmd_valid  in  1  command byte present.
cmd_data  in  8  command byte, sent LSB first.
cmd_ready  out  1  high in IDLE; a byte is accepted when cmd_valid and cmd_ready are both high.
ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous).
ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous).
ps2_clk_oe  out  1  1 = pull PS2_CLK low.
ps2_dat_oe  out  1  1 = pull PS2_DAT low.
busy  out  1  high whenever not IDLE; the receiver uses it to ignore frames during transmission.
tx_done  out  1  one-cycle pulse on successful acknowledged transfer.
tx_error  out  1  one-cycle pulse on missing acknowledge or timeout.

Behaviour:
- Reset (synchronous) state and outputs:
  - state IDLE, cmd_ready=1, both oe=0, busy=0, tx_done=0, tx_error=0, counters 0.
  - Reset mid-transfer releases both lines on the next edge; no done/error pulse.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in pass through 2-FF synchronizers.
  - fall = previous synchronized clk high AND current synchronized clk low.
- Handshake:
  - On accept, latch cmd_data and parity = ~^cmd_data (odd parity).
  - Bit index = 0. Go to INHIBIT.
  - cmd_valid while busy is ignored; the byte is not queued.
- States:
  - IDLE: wait for accept.
  - INHIBIT: clk_oe=1, dat_oe=0; count INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: one cycle with clk_oe=1 and dat_oe=1 (start bit 0); then go to SHIFT.
  - SHIFT: clk_oe=0. On each fall:
    - index 0..7 drives dat_oe = ~data[index];
    - index 8 drives dat_oe = ~parity;
    - index 9 drives dat_oe = 0 (stop bit 1, line released).
    - Increment index. The fall following index 9 goes to ACK.
  - ACK: on that same fall, sample synchronized data. Low means acknowledged and goes to WAIT_IDLE. High means pulse tx_error and go to IDLE.
  - WAIT_IDLE: wait until synchronized clk and data are both high, pulse tx_done, go to IDLE.
- Timeout:
  - The counter clears on every fall and on entry to SHIFT, and runs in SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE.
  - If the timeout and a fall occur in the same cycle, the fall wins.
- Widths: each counter is $clog2(max+1) bits; bit index is 4 bits.
- Line rule: clk_oe is never asserted outside INHIBIT and REQ. dat_oe is 0 in IDLE.
- Latency: the first data bit appears on the first fall after REQ. Each data bit changes one synchronizer delay (3 clk) after the pad falls.

Optional Feature:
PS2_HOST_TX_FILTER_EN
- Defined: the synchronized clock passes through an 8-sample majority/stability filter. The filtered level changes only after 8 consecutive equal samples, which rejects glitches shorter than 160 ns. fall is derived from the filtered level, adding 8 clk latency.
- Undefined: no filter; fall comes directly from the 2-FF output.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_ACK_BYTE=8'hFA;
  - default cycle constants.
- One sub-module, ps2_line_sync: 2-FF synchronizer, the optional filter, and falling-edge detection; instantiated once per line. It is reused later by the receiver.

Test Plan:
- Send 0xED through a bench device model (10-13 kHz clock):
  - clk_oe stays low for exactly 6000 cycles, then REQ.
  - Sampled bits are 0,1,0,1,1,0,1,1,1; parity 1, stop 1.
  - Model ACKs low, tx_done pulses once, busy drops.
- Send 0x01: parity bit 0; send 0xFF: parity bit 1; both complete with tx_done.
- Device model never clocks after REQ: tx_error pulses exactly TIMEOUT_CYCLES cycles after REQ exit; both oe are 0 afterwards.
- Model leaves data high at the ACK clock: tx_error pulses, no tx_done, back to IDLE.
- Assert resetn=0 during bit 4: next edge gives oe=0/0, cmd_ready=1, no pulses. A new 0xFF then transfers cleanly.
- cmd_valid held high with changing cmd_data while busy: only the first byte is transmitted; cmd_ready is 0 throughout.
